// File: rtl/sar_byte_search_if.sv
// Handshake and comparator bundle for the successive-approximation byte search.
// The master side requests searches and closes the comparator loop; the slave side is the controller.
interface sar_byte_search_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             cmp_gt;
    logic             cmp_lt;
    logic             cmp_eq;
    logic [WIDTH-1:0] trial;
    logic             busy;
    logic             done;
    logic             err;
    logic [WIDTH-1:0] result;

    modport master (
        output start, cmp_gt, cmp_lt, cmp_eq,
        input  trial, busy, done, err, result
    );

    modport slave (
        input  start, cmp_gt, cmp_lt, cmp_eq,
        output trial, busy, done, err, result
    );
endinterface

// File: rtl/sar_byte_search.sv
// Successive-approximation controller: drives a trial code into an external magnitude
// comparator and binary-searches MSB first until the hidden target is recovered.
module sar_byte_search #(
    parameter int WIDTH      = 8,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    sar_byte_search_if.slave  bus
);
    localparam int               PTR_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1'b1);
    localparam logic [WIDTH-1:0] MSB_CODE = ONE << (WIDTH - 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] trial_r;
    logic [PTR_W-1:0] ptr_r;
    logic             busy_r;
    logic             done_r;
    logic             err_r;
    logic [WIDTH-1:0] result_r;

    logic             flags_ok_s;
    logic             last_s;
    logic [WIDTH-1:0] bit_mask_s;
    logic [WIDTH-1:0] decided_s;
    logic [WIDTH-1:0] next_trial_s;

    // A healthy comparator reports exactly one relation; anything else is a wiring or stuck-at fault.
    function automatic logic one_hot3(input logic a, input logic b, input logic c);
        return (a ^ b ^ c) & ~(a & b & c);
    endfunction

    // Bit decision for the current pointer and the trial code for the next compare.
    always_comb begin
        flags_ok_s   = one_hot3(bus.cmp_gt, bus.cmp_lt, bus.cmp_eq);
        last_s       = (ptr_r == '0);
        bit_mask_s   = ONE << ptr_r;
        decided_s    = trial_r;
        next_trial_s = trial_r;
        if (bus.cmp_gt) begin
            decided_s = trial_r & ~bit_mask_s;
        end else begin
            decided_s = trial_r;
        end
        if (last_s) begin
            next_trial_s = decided_s;
        end else begin
            next_trial_s = decided_s | (bit_mask_s >> 1);
        end
    end

    // Search state machine; every output is a register so the only combinational loop
    // is trial -> external comparator -> flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            trial_r  <= '0;
            ptr_r    <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
            result_r <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        trial_r <= MSB_CODE;
                        ptr_r   <= LAST_PTR;
                        err_r   <= 1'b0;
                        busy_r  <= 1'b1;
                        state_r <= ST_SEARCH;
                    end else begin
                        trial_r <= '0;
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_SEARCH: begin
                    if (!flags_ok_s || (EARLY_EXIT && bus.cmp_eq) || last_s) begin
                        if (!flags_ok_s) begin
                            err_r    <= 1'b1;
                            result_r <= '0;
                        end else if (EARLY_EXIT && bus.cmp_eq) begin
                            result_r <= trial_r;
                        end else begin
                            result_r <= decided_s;
                        end
                        trial_r <= '0;
                        ptr_r   <= '0;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= ST_DONE;
                    end else begin
                        trial_r <= next_trial_s;
                        ptr_r   <= ptr_r - PTR_W'(1);
                        state_r <= ST_SEARCH;
                    end
                end
                ST_DONE: begin
                    // start is deliberately not sampled here; it must be seen again in IDLE.
                    trial_r <= '0;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    trial_r <= '0;
                    ptr_r   <= '0;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.trial  = trial_r;
    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
    assign bus.err    = err_r;
    assign bus.result = result_r;
endmodule

// File: tb/tb_sar_byte_search.sv
// Self-checking bench: two controllers (early exit on / off) share one start and one
// hidden target, each closing its loop through a behavioural magnitude comparator.
module tb_sar_byte_search;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         force_bad = 1'b0;
    logic [W-1:0] target = '0;

    int n_cmp = 0;
    int n_bad = 0;
    int n_starts = 0;
    int n_dones = 0;

    always #5 clk = ~clk;

    sar_byte_search_if #(.WIDTH(W)) bus0 ();
    sar_byte_search_if #(.WIDTH(W)) bus1 ();

    assign bus0.start  = start;
    assign bus1.start  = start;
    assign bus0.cmp_gt = force_bad | (bus0.trial > target);
    assign bus0.cmp_lt = force_bad | (bus0.trial < target);
    assign bus0.cmp_eq = ~force_bad & (bus0.trial == target);
    assign bus1.cmp_gt = force_bad | (bus1.trial > target);
    assign bus1.cmp_lt = force_bad | (bus1.trial < target);
    assign bus1.cmp_eq = ~force_bad & (bus1.trial == target);

    sar_byte_search #(.WIDTH(W), .EARLY_EXIT(1'b1)) dut_ee   (.clk(clk), .rst_n(rst_n), .bus(bus0));
    sar_byte_search #(.WIDTH(W), .EARLY_EXIT(1'b0)) dut_full (.clk(clk), .rst_n(rst_n), .bus(bus1));

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Binary search code for compare j: target's bits above the tried bit, then the tried bit set.
    function automatic logic [W-1:0] exp_trial(input logic [W-1:0] tgt, input int j);
        int sh;
        int v;
        if (j < 1 || j > W) return '0;
        sh = W - j;
        v  = int'(tgt);
        v  = (v >> (sh + 1)) << (sh + 1);
        return W'(v + (1 << sh));
    endfunction

    task automatic run(input logic [W-1:0] tgt, input int bad_at, input bit hold);
        int idx0 = 0;
        int idx1 = 0;
        int n = 1;
        int k0;
        int k1;
        bit d0 = 1'b0;
        bit d1 = 1'b0;
        bit exp_err;
        exp_err = (bad_at > 0);
        k0 = W;
        for (int j = W; j >= 1; j--) begin
            if (exp_trial(tgt, j) == tgt) k0 = j;
        end
        k1 = W;
        if (exp_err) begin
            k0 = bad_at;
            k1 = bad_at;
        end
        if (bus0.done || bus1.done) begin
            @(posedge clk); #1;
        end
        target = tgt;
        start  = 1'b1;
        @(posedge clk); #1;
        n_starts += 2;
        if (!hold) start = 1'b0;
        check_eq("start_busy", {31'd0, bus0.busy}, 32'd1);
        check_eq("start_err", {31'd0, bus0.err}, 32'd0);
        while (!(d0 && d1) && n < 3 * W) begin
            if (bus0.busy && !d0) begin
                idx0++;
                check_eq("trial_ee", 32'(bus0.trial), 32'(exp_trial(tgt, idx0)));
            end
            if (bus1.busy && !d1) begin
                idx1++;
                check_eq("trial_full", 32'(bus1.trial), 32'(exp_trial(tgt, idx1)));
            end
            force_bad = exp_err && bus0.busy && (idx0 == bad_at);
            @(posedge clk); #1;
            n++;
            force_bad = 1'b0;
            if (bus0.done && !d0) begin
                d0 = 1'b1;
                n_dones++;
                check_eq("lat_ee", 32'(n), 32'(k0 + 1));
                check_eq("result_ee", 32'(bus0.result), exp_err ? 32'd0 : 32'(tgt));
                check_eq("err_ee", {31'd0, bus0.err}, {31'd0, exp_err});
                check_eq("busy_done_ee", {31'd0, bus0.busy}, 32'd0);
                check_eq("trial_done_ee", 32'(bus0.trial), 32'd0);
            end
            if (bus1.done && !d1) begin
                d1 = 1'b1;
                n_dones++;
                check_eq("lat_full", 32'(n), 32'(k1 + 1));
                check_eq("result_full", 32'(bus1.result), exp_err ? 32'd0 : 32'(tgt));
                check_eq("err_full", {31'd0, bus1.err}, {31'd0, exp_err});
            end
        end
        check_eq("timeout", {31'd0, (d0 && d1)}, 32'd1);
    endtask

    initial begin
        // reset state
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_trial", 32'(bus0.trial), 32'd0);
        check_eq("rst_busy", {31'd0, bus0.busy}, 32'd0);
        check_eq("rst_done", {31'd0, bus0.done}, 32'd0);
        check_eq("rst_err", {31'd0, bus0.err}, 32'd0);
        check_eq("rst_result", 32'(bus0.result), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run(8'h5A, 0, 1'b0);
        run(8'h00, 0, 1'b0);
        run(8'hFF, 0, 1'b0);
        run(8'h80, 0, 1'b0);

        // illegal flags on compare 3, err held, then cleared by the next start
        run(8'h5A, 3, 1'b0);
        @(posedge clk); #1;
        check_eq("err_held", {31'd0, bus0.err}, 32'd1);
        run(8'h33, 0, 1'b0);

        // start held through SEARCH and DONE: restart only once back in IDLE
        run(8'h37, 0, 1'b1);
        @(posedge clk); #1;
        check_eq("hold_idle_busy", {31'd0, bus0.busy}, 32'd0);
        check_eq("hold_idle_done", {31'd0, bus0.done}, 32'd0);
        @(posedge clk); #1;
        check_eq("hold_restart", {30'd0, bus1.busy, bus0.busy}, 32'd3);
        start = 1'b0;
        repeat (W + 2) @(posedge clk);
        #1;

        // asynchronous reset during compare 4
        target = 8'hC3;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("pre_rst_trial", 32'(bus0.trial), 32'(exp_trial(8'hC3, 4)));
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_trial", 32'(bus0.trial), 32'd0);
        check_eq("mid_rst_busy", {30'd0, bus1.busy, bus0.busy}, 32'd0);
        check_eq("mid_rst_result", 32'(bus0.result), 32'd0);
        check_eq("mid_rst_done", {30'd0, bus1.done, bus0.done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check_eq("post_rst_quiet", {28'd0, bus1.busy, bus0.busy, bus1.done, bus0.done}, 32'd0);
        end

        // randomised back-to-back searches
        n_starts = 0;
        n_dones  = 0;
        for (int i = 0; i < 256; i++) begin
            run(W'($urandom_range(0, (1 << W) - 1)), 0, 1'b0);
        end
        check_eq("done_count", 32'(n_dones), 32'(n_starts));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sar_byte_search.md
Name: sar_byte_search

Overview:
- Sequential successive-approximation controller that sits on the operand side of the 8-bit magnitude comparator.
- Drives a trial byte into the comparator's A inputs while an unknown target byte sits on its B inputs.
- Reads back the three comparator flags and binary-searches, MSB first, until the target value is recovered.
- Used wherever a value is only observable through a comparator, e.g. threshold/DAC code search.

Parameters:
- WIDTH, 8: trial/result width in bits. Search takes at most WIDTH compare cycles.
- EARLY_EXIT, 1: 1 = finish on the first cycle cmp_eq is high; 0 = always run all WIDTH compare cycles.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a new search; sampled only in IDLE.
- cmp_gt  input  1  comparator A_greater: trial > target. Combinational from trial, valid in the same cycle.
- cmp_lt  input  1  comparator B_greater: trial < target.
- cmp_eq  input  1  comparator A_equal_B: trial == target.
- trial  output  WIDTH  value driven to comparator A inputs.
- busy  output  1  high while searching.
- done  output  1  single-cycle pulse: search finished.
- err  output  1  high with done if an illegal flag combination was seen; held until next start.
- result  output  WIDTH  recovered value; valid from done, held until next accepted start.

Behaviour:
- Reset, asynchronous on rst_n low, effective immediately, including mid-search:
  - state=IDLE.
  - trial=0, busy=0, done=0, err=0, result=0, bit pointer=0.
- States: IDLE, SEARCH, DONE.
- IDLE:
  - trial=0.
  - On a clock edge with start=1: trial <= 1 << (WIDTH-1), ptr <= WIDTH-1, err <= 0, busy <= 1, go to SEARCH.
  - start=0 keeps IDLE; result holds.
- SEARCH, once per cycle, flags sampled at the clock edge:
  - Legality: exactly one of cmp_gt/cmp_lt/cmp_eq must be high. Otherwise err <= 1, result <= 0, go to DONE.
  - If cmp_eq=1 and EARLY_EXIT=1: result <= trial, go to DONE.
  - Otherwise, decide the bit: if cmp_gt=1, clear trial[ptr]; else keep it. Call the decided value t'.
  - If ptr==0: result <= t', go to DONE.
  - Else: trial <= t' | (1 << (ptr-1)), ptr <= ptr-1, stay in SEARCH.
  - start is ignored while in SEARCH.
- DONE:
  - Lasts exactly one cycle: done=1, busy=0, trial=0.
  - Unconditionally returns to IDLE. A start asserted during DONE is ignored; it must be re-asserted in IDLE.
- Timing:
  - Call the edge that accepts start E0. Compare k is sampled at edge E(k).
  - done is high in the cycle after the finishing compare, i.e. after E(k), k ≤ WIDTH.
  - Maximum start-to-done latency is WIDTH+1 cycles; with EARLY_EXIT=0 it is always WIDTH+1.
- Arithmetic:
  - All values are unsigned.
  - No arithmetic carry; only per-bit set/clear.
  - result is exact for any target 0..2^WIDTH-1, given legal flags.
- Boundary values:
  - Target 0: all compares return gt and the final trial driven is 0x01. result=0x00; eq is never seen.
  - Target all-ones: eq is seen on the last compare.
- Outputs are registered; the combinational path runs only from trial through the external comparator back to the flags.

Test Plan:
- Target 0x5A, EARLY_EXIT=1, pulse start:
  - trial sequence 0x80, 0x40, 0x60, 0x50, 0x58, 0x5C, 0x5A.
  - eq seen on compare 7; done one cycle later; result=0x5A, err=0, busy low with done.
- Target 0x00:
  - trial sequence 0x80, 0x40, 0x20, 0x10, 0x08, 0x04, 0x02, 0x01, all gt.
  - done after E8; result=0x00. Target 0xFF: trials 0x80, 0xC0, …, 0xFF; result=0xFF after E8.
- EARLY_EXIT=0, target 0x80:
  - eq on first compare, search continues through 0xC0 (gt), …, 0x81 (gt).
  - done exactly 9 cycles after start accepted; result=0x80.
- Illegal flags:
  - Force cmp_gt=1 and cmp_lt=1 on compare 3.
  - done pulses next cycle with err=1, result=0x00. Next start clears err, and a normal search for 0x33 returns 0x33.
- Reset and start handling:
  - Deassert rst_n during compare 4 of a search: all outputs 0 immediately; after release, IDLE with no done pulse.
  - start held high through SEARCH and DONE: exactly one search runs; a new search begins only on start seen in IDLE.
- Randomised check:
  - 256 targets, each back-to-back, using the comparator model as feedback.
  - result==target for all; done count == start-accept count.
